// File: rtl/barrel_shifter.sv
// Registered 32-bit logarithmic barrel shifter: logical left/right and arithmetic right, one-cycle latency.
// Optional rotate modes are enabled by defining BARREL_SHIFTER_ROTATE_EN.
module barrel_shifter #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  input  logic               right,
`ifdef BARREL_SHIFTER_ROTATE_EN
  input  logic               rotate,
`endif
  input  logic               in_valid,
  output logic [WIDTH-1:0]   O,
  output logic               out_valid
);

  logic             rot;
  logic             fill;
  logic [WIDTH-1:0] stage [SHAMT_W+1];
  logic [WIDTH-1:0] o_q, o_d;
  logic             valid_q, valid_d;

`ifdef BARREL_SHIFTER_ROTATE_EN
  assign rot = rotate;
`else
  assign rot = 1'b0;
`endif

  // Sign fill only for arithmetic right shifts; rotate takes its fill from the bits shifted out.
  assign fill     = right & arith & ~rot & A[WIDTH-1];
  assign stage[0] = A;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [S-1:0]     rfill;
    logic [S-1:0]     lfill;
    logic [WIDTH-1:0] shifted;

    assign rfill   = rot ? stage[k][S-1:0] : {S{fill}};
    assign lfill   = rot ? stage[k][WIDTH-1 -: S] : '0;
    assign shifted = right ? {rfill, stage[k][WIDTH-1:S]}
                           : {stage[k][WIDTH-1-S:0], lfill};
    assign stage[k+1] = shamt[k] ? shifted : stage[k];
  end

  always_comb begin
    o_d     = o_q;
    valid_d = in_valid;
    if (in_valid) o_d = stage[SHAMT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign O         = o_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed vectors, streaming/hold, async reset and randomized ops.
module tb_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        right = 1'b0;
  logic        rot = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] O;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  barrel_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .shamt     (shamt),
    .arith     (arith),
    .right     (right),
`ifdef BARREL_SHIFTER_ROTATE_EN
    .rotate    (rot),
`endif
    .in_valid  (in_valid),
    .O         (O),
    .out_valid (out_valid)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input int sh,
                                        input logic r, input logic ar, input logic ro);
    logic [63:0] dbl;
    if (ro) begin
      dbl = {a, a};
      if (r) return dbl[sh +: 32];
      else   return dbl[(32 - sh) +: 32];
    end
    if (!r)   return a << sh;
    if (ar)   return $unsigned($signed(a) >>> sh);
    return a >> sh;
  endfunction

  task automatic apply(input logic [31:0] a, input int sh, input logic r,
                       input logic ar, input logic ro, input logic v);
    A = a; shamt = sh[4:0]; right = r; arith = ar; rot = ro; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    A = $urandom; shamt = 5'($urandom); right = 1'($urandom); arith = 1'($urandom);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (O !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: O=%h out_valid=%b required O=00000000 out_valid=0", O, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] vec_a  [7] = '{32'h00000116, 32'h80000010, 32'h80000010, 32'h00000001,
                                32'hFFFFFFFF, 32'h12345678, 32'h0000F000};
    int          vec_sh [7] = '{3, 4, 4, 31, 31, 8, 12};
    logic        vec_r  [7] = '{1, 1, 1, 0, 1, 0, 0};
    logic        vec_ar [7] = '{0, 1, 0, 0, 1, 1, 0};
    logic [31:0] vec_o  [7] = '{32'h00000022, 32'hF8000001, 32'h08000001, 32'h80000000,
                                32'hFFFFFFFF, 32'h34567800, 32'h0F000000};
    for (int i = 0; i < 7; i++) begin
      apply(vec_a[i], vec_sh[i], vec_r[i], vec_ar[i], 1'b0, 1'b1);
      total++;
      if (O !== vec_o[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d: O=%h out_valid=%b required O=%h out_valid=1",
                 i, O, out_valid, vec_o[i]);
      end
    end
    for (int m = 0; m < 4; m++) begin
      apply(32'hDEADBEEF, 0, m[0], m[1], 1'b0, 1'b1);
      total++;
      if (O !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL zero_shift_mode%0d: O=%h required DEADBEEF", m, O);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_o [3] = '{32'h200, 32'h400, 32'h800};
    for (int i = 0; i < 3; i++) begin
      apply(32'h00000100, i + 1, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (O !== exp_o[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d: O=%h out_valid=%b required O=%h out_valid=1",
                 i, O, out_valid, exp_o[i]);
      end
    end
    apply(32'hFFFF0000, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (O !== 32'h800 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold: O=%h out_valid=%b required O=00000800 out_valid=0", O, out_valid);
    end
  endtask

  task automatic test_async_reset;
    apply(32'h0000ABCD, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (O !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: O=%h out_valid=%b required O=00000000 out_valid=0", O, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] exp_o = '0;
    logic        exp_v;
    logic [31:0] a;
    int          sh;
    logic        r, ar, ro, v;
    for (int i = 0; i < 300; i++) begin
      a  = $urandom;
      sh = int'($urandom_range(31, 0));
      r  = 1'($urandom); ar = 1'($urandom);
      v  = ($urandom_range(3, 0) != 0);
`ifdef BARREL_SHIFTER_ROTATE_EN
      ro = 1'($urandom);
`else
      ro = 1'b0;
`endif
      apply(a, sh, r, ar, ro, v);
      if (v) exp_o = model(a, sh, r, ar, ro);
      exp_v = v;
      total++;
      if (O !== exp_o || out_valid !== exp_v) begin
        bad++;
        $display("FAIL random_%0d: A=%h sh=%0d r=%b ar=%b rot=%b v=%b O=%h ov=%b required O=%h ov=%b",
                 i, a, sh, r, ar, ro, v, O, out_valid, exp_o, exp_v);
      end
    end
  endtask

`ifdef BARREL_SHIFTER_ROTATE_EN
  task automatic test_rotate;
    apply(32'h00000001, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (O !== 32'h80000000) begin
      bad++;
      $display("FAIL rotate_right: O=%h required 80000000", O);
    end
    apply(32'h80000000, 4, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (O !== 32'h00000008) begin
      bad++;
      $display("FAIL rotate_left: O=%h required 00000008", O);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef BARREL_SHIFTER_ROTATE_EN
    test_rotate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- 32-bit logarithmic barrel shifter for the integer ALU path; supports logical left, logical right and arithmetic right shifts by 0..31.
- Combinational shift core feeds a single output register, giving a fixed one-cycle latency.
- A valid strobe marks which results are fresh.

Parameters:
- WIDTH, 32, data width; must be a power of two ≥ 2.
- SHAMT_W, $clog2(WIDTH) = 5, shift-amount width; derived and not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand to shift.
- shamt  input  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- arith  input  1  1 = arithmetic (sign-fill) for right shifts; ignored when right=0.
- right  input  1  1 = shift right, 0 = shift left.
- in_valid  input  1  operands valid this cycle.
- O  output  WIDTH  registered shift result.
- out_valid  output  1  O holds the result of an operation accepted on the previous edge.

Behaviour:
- Reset: rst_n low asynchronously forces O = 0 and out_valid = 0, independent of clk. Release is sampled on the next rising edge.
- Core: SHAMT_W cascaded mux stages. Stage k shifts by 2^k when shamt[k] = 1, otherwise passes through.
- Fill bit:
  - Left shift: 0.
  - Logical right (right=1, arith=0): 0.
  - Arithmetic right (right=1, arith=1): A[WIDTH-1].
- Left shift: O = A << shamt, truncated to WIDTH bits.
- shamt = 0: O = A for every mode.
- shamt = WIDTH-1, right arithmetic: O = all copies of A[WIDTH-1].
- arith = 1 with right = 0: identical to a logical left shift.
- Latency and valid:
  - Exactly one cycle: on a rising edge with in_valid = 1, O ← shift(A, shamt, mode) and out_valid ← 1.
  - Rising edge with in_valid = 0: O holds its previous value and out_valid ← 0.
  - Back-to-back valid inputs give back-to-back results, one per cycle. No backpressure and no stall.
- Reset mid-operation: any in-flight result is discarded, O = 0, out_valid = 0.
- Inputs are sampled only at the clock edge. No combinational path from inputs to outputs.

Optional Feature:
- Macro: BARREL_SHIFTER_ROTATE_EN.
- When defined:
  - Adds input port rotate (1 bit).
  - rotate = 1 makes the fill bits come from the bits shifted out: rotate right when right=1, rotate left when right=0.
  - arith is ignored while rotate = 1.
  - Latency and reset behaviour are unchanged.
- When undefined: no rotate port exists, and only the three shift modes are supported.

Test Plan:
- Reset: hold rst_n = 0 with random inputs and in_valid = 1 → O = 0x00000000 and out_valid = 0. Assert rst_n = 0 mid-stream with no clock edge → outputs clear immediately.
- Logical right: A = 0x00000116, shamt = 3, right = 1, arith = 0, in_valid = 1 → one edge later O = 0x00000022, out_valid = 1.
- Arithmetic right: A = 0x80000010, shamt = 4, right = 1, arith = 1 → O = 0xF8000001. Same operands with arith = 0 → O = 0x08000001.
- Left shift and boundaries:
  - A = 0x00000001, shamt = 31, right = 0 → O = 0x80000000.
  - A = 0xDEADBEEF, shamt = 0 in all modes → O = 0xDEADBEEF.
  - A = 0xFFFFFFFF, shamt = 31, arithmetic right → O = 0xFFFFFFFF.
- Streaming and hold:
  - Three consecutive valid ops (shamt 1, 2, 3 on A = 0x00000100, left) → O = 0x200, 0x400, 0x800 on successive cycles.
  - Then in_valid = 0 → O holds 0x800 and out_valid = 0.
- Rotate (with BARREL_SHIFTER_ROTATE_EN): A = 0x00000001, shamt = 1, right = 1, rotate = 1 → O = 0x80000000. A = 0x80000000, shamt = 4, right = 0, rotate = 1 → O = 0x00000008.
